inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time writer for the instruction memory. Accepts a byte stream (length header followed by big-endian instruction words) and assembles 32-bit words. Writes them to consecutive word addresses of the instruction ROM's write port. Holds the instruction-fetch chip-enable inactive while loading and releases it only once the image is fully written, so the CPU fetches a complete program.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; capacity is 2^ADDR_W words (1024 by default).

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: begin a load; sampled only in IDLE or DONE/ERR.
- `byte_valid`  in  1: `byte_data` holds a byte.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader can accept a byte; a transfer occurs when `byte_valid && byte_ready`.
- `mem_we`  out  1: one-cycle write strobe to instruction memory.
- `mem_waddr`  out  ADDR_W: word address of the write.
- `mem_wdata`  out  32: instruction word.
- `fetch_ce`  out  1: instruction-fetch enable; 0 = ROM disabled (data forced to zero), 1 = enabled.
- `busy`  out  1: load in progress.
- `done`  out  1: last load completed successfully (level).
- `err`  out  1: last load aborted (level).

## Operation
- States:
  - IDLE
  - LEN_HI: byte = count[15:8]
  - LEN_LO: byte = count[7:0]
  - DATA
  - CSUM (only with the macro)
  - DONE
  - ERR
- IDLE/DONE/ERR with `start`=1 go to LEN_HI. Entering LEN_HI clears `done` and `err`, zeroes the word address and the byte index, and drives `fetch_ce`=0.
- Length header:
  - After LEN_LO accepts a byte: if count > 2^ADDR_W, go to ERR.
  - If count == 0, go to CSUM when enabled, else DONE.
  - Otherwise go to DATA.
- DATA: a 2-bit byte index selects the lane. Index 0 is bits [31:24], index 3 is bits [7:0], so the first byte on the stream is the MSB. On the 4th byte, the assembled word is registered for writing, the address is incremented and the word counter is decremented. When the counter reaches 0, go to CSUM or DONE.
- Address wraps are impossible because count ≤ 2^ADDR_W is enforced. When count == 2^ADDR_W, the final write uses address 2^ADDR_W−1.
- `byte_ready`=1 only in LEN_HI, LEN_LO, DATA and CSUM.
- `busy`=1 in LEN_HI through CSUM.
- `fetch_ce`=1 only in DONE.
- `start` during a load is ignored.
- `byte_valid` outside a ready state is ignored; no byte is consumed.
- Reset mid-load returns to IDLE immediately. Partially written memory is left as is; `fetch_ce` stays 0.

## Timing
- Reset values:
  - state IDLE, all counters 0
  - `byte_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0
  - `fetch_ce`=0, `busy`=0, `done`=0, `err`=0
- One byte per cycle at most; zero-wait acceptance with back-to-back transfers.
- Write latency: the 4th byte of a word is accepted in cycle N; in cycle N+1 `mem_we`=1 with that word's address and data. `mem_we` is a single-cycle pulse.
- Completion: `done`=1 and `fetch_ce`=1 in the cycle after the final `mem_we` (N+2). This guarantees the final word is in memory before the first fetch.
- If count == 0 (no checksum), DONE is entered one cycle after the LEN_LO transfer.
- `start` is accepted in the cycle it is sampled. LEN_HI is active, `byte_ready`=1, the next cycle.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: one extra trailing byte is expected. It must equal the XOR of all header and data bytes.
  - The CSUM state accepts it. On match go to DONE; on mismatch go to ERR. Either way the state is entered the cycle after the checksum transfer, and data already written is not rolled back.
  - In ERR, `fetch_ce` stays 0.
  - Undefined: no CSUM state. DATA goes directly to DONE; the stream is exactly 2 + 4×count bytes.

## Test plan
- Load 2 words.
  - Stimulus: stream 00 02 34 23 00 01 34 23 11 00, contiguous.
  - Response: `mem_we` pulses at addresses 0 and 1 with data 0x34230001 and 0x34231100. `done`=1 and `fetch_ce`=1 one cycle after the second pulse.
- Throttled stream: same image with `byte_valid` toggling every other cycle. Response: identical writes, with no bytes lost or duplicated.
- Zero and oversize headers:
  - 00 00 → DONE with no `mem_we`.
  - 04 01 with ADDR_W=10 → ERR, `err`=1, `fetch_ce`=0, no writes.
- Reset and restart:
  - Assert `rst`=0 after 5 data bytes. Response: next cycle all outputs are at reset values.
  - Then `start` plus the 1-word stream 00 01 08 00 00 00. Response: write 0x08000000 at address 0.
- With `LOADER_CHECKSUM_EN`:
  - Stream 00 01 00 00 00 0C 0D → `done`=1.
  - Trailing byte 0E instead → `err`=1, `fetch_ce`=0, and the word is still written at address 0.

Source files
------------

// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_if
//  Description : Byte-stream input and instruction-memory write port of the
//                boot-time instruction loader, bundled as one interface.
//                  byte_valid / byte_data / byte_ready : stream handshake
//                  mem_we / mem_waddr / mem_wdata      : ROM write port
//                modport slave  : the loader's view (consumes bytes, writes)
//                modport master : the environment's view (supplies bytes,
//                                 observes writes)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_loader_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Boot-time instruction-memory writer. Takes a byte stream
//                (16-bit big-endian word count, then big-endian 32-bit words),
//                writes the words to consecutive ROM addresses starting at 0,
//                and keeps instruction fetch disabled until the whole image
//                is in memory.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-low reset
//                start    - begin a load (honoured in IDLE/DONE/ERR only)
//                bus      - inst_loader_if.slave: byte stream + ROM write port
//                fetch_ce - instruction-fetch enable, high only in DONE
//                busy     - load in progress
//                done     - last load completed successfully (level)
//                err      - last load aborted (level)
//  Options     : LOADER_CHECKSUM_EN - expect one trailing byte equal to the
//                XOR of all header and data bytes; mismatch ends in ERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    inst_loader_if.slave    bus,
    output logic            fetch_ce,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_LEN_HI = 3'd1;
    localparam logic [2:0] C_LEN_LO = 3'd2;
    localparam logic [2:0] C_DATA   = 3'd3;
    localparam logic [2:0] C_CSUM   = 3'd4;
    localparam logic [2:0] C_DONE   = 3'd5;
    localparam logic [2:0] C_ERR    = 3'd6;

    // Largest legal word count; 17 bits so 2^16 is representable.
    localparam logic [16:0] C_MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]        state_q,     state_d;
    logic [15:0]       count_q,     count_d;     // header, then words remaining
    logic [ADDR_W-1:0] addr_q,      addr_d;      // address of next word
    logic [1:0]        idx_q,       idx_d;       // byte lane within word
    logic [23:0]       word_q,      word_d;      // first three bytes of word
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q,      csum_d;
    logic              w_last_byte;
`endif

    logic        w_byte_ready;
    logic        w_xfer;
    logic        w_start_ok;
    logic [15:0] w_len;

    assign w_xfer     = bus.byte_valid && w_byte_ready;
    assign w_start_ok = start && ((state_q == C_IDLE) || (state_q == C_DONE) ||
                                  (state_q == C_ERR));
    // Full count as it stands once the low header byte is on the bus.
    assign w_len      = {count_q[15:8], bus.byte_data};
`ifdef LOADER_CHECKSUM_EN
    assign w_last_byte = (state_q == C_DATA) && w_xfer && (idx_q == 2'd3) &&
                         (count_q == 16'd1);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE, C_DONE, C_ERR: begin
                if (start) state_d = C_LEN_HI;
            end
            C_LEN_HI: begin
                if (w_xfer) state_d = C_LEN_LO;
            end
            C_LEN_LO: begin
                if (w_xfer) begin
                    if ({1'b0, w_len} > C_MAX_WORDS) begin
                        state_d = C_ERR;
                    end else if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = C_CSUM;
`else
                        state_d = C_DONE;
`endif
                    end else begin
                        state_d = C_DATA;
                    end
                end
            end
            C_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                // The final write lands while the checksum byte is awaited.
                if (w_last_byte) state_d = C_CSUM;
`else
                // count_q==0 here is a drain cycle: the final write strobe is
                // on the bus, so DONE (and fetch_ce) follows one cycle later.
                if (count_q == 16'd0) state_d = C_DONE;
`endif
            end
            C_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_xfer) state_d = (bus.byte_data == csum_q) ? C_DONE : C_ERR;
`else
                state_d = C_IDLE;
`endif
            end
            default: state_d = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_byte_ready = 1'b0;
        busy         = 1'b0;
        fetch_ce     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state_q)
            C_LEN_HI, C_LEN_LO, C_CSUM: begin
                w_byte_ready = 1'b1;
                busy         = 1'b1;
            end
            C_DATA: begin
                w_byte_ready = (count_q != 16'd0);
                busy         = 1'b1;
            end
            C_DONE: begin
                fetch_ce = 1'b1;
                done     = 1'b1;
            end
            C_ERR: begin
                err = 1'b1;
            end
            default: begin
                w_byte_ready = 1'b0;
            end
        endcase
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_waddr  = mem_waddr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        count_d     = count_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        if (w_xfer && (state_q != C_CSUM)) csum_d = csum_q ^ bus.byte_data;
        if (w_start_ok) csum_d = 8'd0;
`endif
        if (w_start_ok) begin
            count_d = 16'd0;
            addr_d  = '0;
            idx_d   = 2'd0;
        end else if (w_xfer) begin
            case (state_q)
                C_LEN_HI: count_d[15:8] = bus.byte_data;
                C_LEN_LO: count_d       = w_len;
                C_DATA: begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: word_d[23:16] = bus.byte_data;
                        2'd1: word_d[15:8]  = bus.byte_data;
                        2'd2: word_d[7:0]   = bus.byte_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_waddr_d = addr_q;
                            mem_wdata_d = {word_q, bus.byte_data};
                            addr_d      = addr_q + ADDR_W'(1);
                            count_d     = count_q - 16'd1;
                        end
                    endcase
                end
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q     <= 16'd0;
            addr_q      <= '0;
            idx_q       <= 2'd0;
            word_q      <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            count_q     <= count_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_loader
//  Description : Self-checking bench for inst_loader. Images are described
//                as a word count plus a list of words; the bench serialises
//                them into bytes, pushes the expected ROM writes into a
//                scoreboard queue, and a negedge monitor pops and compares
//                every write strobe. End-of-load status and timing are
//                checked against the image description.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic fetch_ce, busy, done, err;

    inst_loader_if #(.ADDR_W(ADDR_W)) bif ();

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bif),
        .fetch_ce (fetch_ce),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_vec        = 0;
    int  n_bad        = 0;
    int  last_xfer_cyc = 0;
    int  last_we_cyc   = -100;
    int  thr_mode      = 0;   // 0 contiguous, 1 every other cycle, 2 random gaps
    bit  noisy         = 1'b0; // toggle start randomly during the load
    wr_t exp_q [$];
    logic [31:0] img_words [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst === 1'b1 && bif.mem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bif.mem_waddr, bif.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bif.mem_waddr), 32'(e.a));
                check("wr_data", bif.mem_wdata, e.d);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_wr(input int idx, input logic [31:0] d);
        wr_t e;
        e.a = idx[ADDR_W-1:0];
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int  gap;
        bit  acc;
        gap = (thr_mode == 1) ? 1 : (thr_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (gap) begin
            bif.byte_valid = 1'b0;
            bif.byte_data  = 8'($urandom);
            start          = noisy ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        start          = noisy ? 1'($urandom) : 1'b0;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (bif.byte_ready === 1'b1) begin
                acc = 1'b1;
                last_xfer_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            $display("FAIL byte_accept_timeout: byte %0h never accepted", b);
            $fatal(1, "byte timeout");
        end
        bif.byte_valid = 1'b0;
        start          = 1'b0;
    endtask

    task automatic do_start();
        start          = 1'b1;
        bif.byte_valid = noisy;      // must be ignored: loader is not ready here
        bif.byte_data  = 8'hA5;
        @(posedge clk); #1;
        start          = 1'b0;
        bif.byte_valid = 1'b0;
        check("lenhi_ready", 32'(bif.byte_ready), 32'd1);
        check("lenhi_busy",  32'(busy),           32'd1);
        check("lenhi_done",  32'(done),           32'd0);
        check("lenhi_err",   32'(err),            32'd0);
        check("lenhi_fce",   32'(fetch_ce),       32'd0);
    endtask

    // Serialise a load of `len` words (taken from img_words) and check the outcome.
    task automatic run_load(input int len, input int mode, input bit nz, input bit bad_cs);
        bit          oversize;
        bit          exp_err;
        int          delay;
        bit          found;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        thr_mode = mode;
        noisy    = nz;
        oversize = (len > MAX_WORDS);
        exp_err  = oversize || (CSUM_ON && bad_cs);
        delay    = (!CSUM_ON && len > 0 && !oversize) ? 2 : 1;
        do_start();
        cs = 8'(len >> 8);
        send_byte(8'(len >> 8));
        cs ^= 8'(len);
        send_byte(8'(len));
        if (!oversize) begin
            for (int i = 0; i < len; i++) begin
                w = img_words[i];
                for (int j = 0; j < 4; j++) begin
                    b = w[31 - 8*j -: 8];
                    cs ^= b;
                    if (j == 3) expect_wr(i, w);
                    send_byte(b);
                end
            end
            if (CSUM_ON) send_byte(bad_cs ? (cs ^ 8'h5A) : cs);
        end
        found = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_bad++;
            $display("FAIL end_timeout: got no done/err, expected one within 12 cycles (len %0d)", len);
        end else begin
            check("end_cycle", 32'(cyc - last_xfer_cyc), 32'(delay));
            check("end_done",  32'(done),       32'(!exp_err));
            check("end_err",   32'(err),        32'(exp_err));
            check("end_fce",   32'(fetch_ce),   32'(!exp_err));
            check("end_busy",  32'(busy),       32'd0);
            check("end_ready", 32'(bif.byte_ready), 32'd0);
            check("end_pending_writes", 32'(exp_q.size()), 32'd0);
            if (len > 0 && !oversize)
                check("we_before_done", 32'(cyc > last_we_cyc), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bif.byte_ready), 32'd0);
        check("rst_we",    32'(bif.mem_we),     32'd0);
        check("rst_waddr", 32'(bif.mem_waddr),  32'd0);
        check("rst_wdata", bif.mem_wdata,       32'd0);
        check("rst_fce",   32'(fetch_ce),       32'd0);
        check("rst_busy",  32'(busy),           32'd0);
        check("rst_done",  32'(done),           32'd0);
        check("rst_err",   32'(err),            32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two-word image, contiguous then throttled.
        img_words = '{32'h34230001, 32'h34231100};
        run_load(2, 0, 1'b0, 1'b0);
        run_load(2, 1, 1'b0, 1'b0);

        // Zero-length and oversize headers.
        run_load(0, 0, 1'b0, 1'b0);
        run_load(1025, 0, 1'b0, 1'b0);

        // Checksum images (bad checksum still writes the word).
        img_words = '{32'h0000000C};
        run_load(1, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b0, 1'b1);

        // Reset after five data bytes, then a fresh one-word load.
        img_words = '{32'hDEADBEEF, 32'h01020304, 32'h55AA55AA};
        thr_mode = 0;
        noisy    = 1'b0;
        do_start();
        send_byte(8'h00);
        send_byte(8'h03);
        expect_wr(0, 32'hDEADBEEF);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h01);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", 32'(bif.byte_ready), 32'd0);
        check("mid_rst_we",    32'(bif.mem_we),     32'd0);
        check("mid_rst_waddr", 32'(bif.mem_waddr),  32'd0);
        check("mid_rst_wdata", bif.mem_wdata,       32'd0);
        check("mid_rst_fce",   32'(fetch_ce),       32'd0);
        check("mid_rst_busy",  32'(busy),           32'd0);
        check("mid_rst_done",  32'(done),           32'd0);
        check("mid_rst_err",   32'(err),            32'd0);
        check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        img_words = '{32'h08000000};
        run_load(1, 0, 1'b0, 1'b0);

        // Full-capacity image: last write must land at address 2^ADDR_W-1.
        img_words.delete();
        for (int i = 0; i < MAX_WORDS; i++) img_words.push_back($urandom);
        run_load(MAX_WORDS, 0, 1'b0, 1'b0);

        // Randomised loads: lengths, throttling, stray start pulses, checksums.
        for (int k = 0; k < 40; k++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 9));
            if (r == 0)      len = 0;
            else if (r == 1) len = int'($urandom_range(MAX_WORDS + 1, 65535));
            else             len = int'($urandom_range(1, 6));
            img_words.delete();
            for (int i = 0; i < 6; i++) img_words.push_back($urandom);
            run_load(len, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
